intr_host_agent: RTL and testbench

INTR_HOST_AGENT -- requirements
Module: intr_host_agent

---
 rtl/intr_pkg.sv | 38 +++
 rtl/intr_host_bus_seq.sv | 87 ++++++++
 rtl/intr_host_agent.sv | 143 ++++++++++++++
 tb/tb_intr_host_agent.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/intr_pkg.sv
`default_nettype none
// ============================================================================
// intr_pkg : shared sizes and one-hot state encoding for intr_host_agent
// Optional feature macro: INTR_HOST_READBACK_EN (adds CFG_RD / CFG_RDGAP)
// Revision : 1.0  initial release
// ============================================================================
package intr_pkg;

  localparam int c_NUM_INTR = 16;
  localparam int c_PRIO_W   = 4;
  localparam int c_ID_W     = 4;

`ifdef INTR_HOST_READBACK_EN
  typedef enum logic [8:0] {
    IDLE      = 9'h001,
    CFG_WR    = 9'h002,
    CFG_GAP   = 9'h004,
    CFG_RD    = 9'h008,
    CFG_RDGAP = 9'h010,
    READY     = 9'h020,
    SVC       = 9'h040,
    ACK       = 9'h080,
    DROP      = 9'h100
  } state_t;
`else
  typedef enum logic [6:0] {
    IDLE    = 7'h01,
    CFG_WR  = 7'h02,
    CFG_GAP = 7'h04,
    READY   = 7'h08,
    SVC     = 7'h10,
    ACK     = 7'h20,
    DROP    = 7'h40
  } state_t;
`endif

endpackage
`default_nettype wire

// File: rtl/intr_host_bus_seq.sv
`default_nettype none
// ============================================================================
// intr_host_bus_seq : penable/pready handshake, inter-access gap and the
//                     configuration-state transitions of intr_host_agent
// Optional feature macro: INTR_HOST_READBACK_EN
// Revision : 1.0  initial release
// ============================================================================
module intr_host_bus_seq
  import intr_pkg::*;
#(
  parameter int PRIO_W = c_PRIO_W
) (
  input  logic              pclk_i,
  input  logic              prst_i,
  input  state_t            state_i,
  input  logic [7:0]        addr_i,
  input  logic [PRIO_W-1:0] field_i,
  input  logic              idx_last_i,
  input  logic              cfg_clr_i,
  input  logic [7:0]        prdata_i,
  input  logic              pready_i,
  output logic [7:0]        paddr_o,
  output logic [7:0]        pwdata_o,
  output logic              pwrite_o,
  output logic              penable_o,
  output state_t            next_o,
  output logic              idx_inc_o,
  output logic              cfg_fin_o,
  output logic              cfg_err_o
);

  logic w_unused_rb;

  assign paddr_o  = addr_i;
  assign pwdata_o = 8'(field_i);
  assign pwrite_o = (state_i == CFG_WR);

  always_comb begin
    next_o    = state_i;
    idx_inc_o = 1'b0;
    cfg_fin_o = 1'b0;
    case (state_i)
      CFG_WR: if (pready_i) next_o = CFG_GAP;
`ifdef INTR_HOST_READBACK_EN
      CFG_GAP: next_o = CFG_RD;
      CFG_RD:  if (pready_i) next_o = CFG_RDGAP;
      CFG_RDGAP: begin
`else
      CFG_GAP: begin
`endif
        // the one-cycle gap state is where the index advances
        if (idx_last_i) begin
          next_o    = READY;
          cfg_fin_o = 1'b1;
        end else begin
          next_o    = CFG_WR;
          idx_inc_o = 1'b1;
        end
      end
      default: next_o = state_i;
    endcase
  end

`ifdef INTR_HOST_READBACK_EN
  logic r_err;

  assign penable_o   = (state_i == CFG_WR) || (state_i == CFG_RD);
  assign cfg_err_o   = r_err;
  assign w_unused_rb = ^prdata_i;

  always_ff @(posedge pclk_i) begin
    if (!prst_i) begin
      r_err <= 1'b0;
    end else if (cfg_clr_i) begin
      r_err <= 1'b0;
    end else if ((state_i == CFG_RD) && pready_i && (prdata_i[PRIO_W-1:0] != field_i)) begin
      r_err <= 1'b1;
    end
  end
`else
  assign penable_o   = (state_i == CFG_WR);
  assign cfg_err_o   = 1'b0;
  assign w_unused_rb = ^{pclk_i, prst_i, cfg_clr_i, prdata_i};
`endif

endmodule
`default_nettype wire

// File: rtl/intr_host_agent.sv
`default_nettype none
// ============================================================================
// intr_host_agent : programs a priority table over a simple bus, then services
//                   interrupts with a programmable duration and a service count
// Optional feature macro: INTR_HOST_READBACK_EN (read-verify of each entry)
// Revision : 1.0  initial release
// ============================================================================
module intr_host_agent
  import intr_pkg::*;
#(
  parameter int NUM_INTR = c_NUM_INTR,
  parameter int PRIO_W   = c_PRIO_W
) (
  input  logic                       pclk_i,
  input  logic                       prst_i,
  input  logic                       cfg_start_i,
  input  logic [NUM_INTR*PRIO_W-1:0] cfg_prio_i,
  output logic                       cfg_done_o,
  output logic                       cfg_err_o,
  output logic [7:0]                 paddr_o,
  output logic [7:0]                 pwdata_o,
  output logic                       pwrite_o,
  output logic                       penable_o,
  input  logic [7:0]                 prdata_i,
  input  logic                       pready_i,
  input  logic [c_ID_W-1:0]          intr_to_service_i,
  input  logic                       intr_valid_i,
  output logic                       intr_serviced_o,
  input  logic [7:0]                 svc_cycles_i,
  output logic                       svc_busy_o,
  output logic [c_ID_W-1:0]          svc_id_o,
  output logic [15:0]                svc_count_o
);

  localparam int c_IDX_W = $clog2(NUM_INTR);

  state_t                      r_state;
  state_t                      w_next;
  state_t                      w_cfg_next;
  logic [NUM_INTR*PRIO_W-1:0]  r_table;
  logic [c_IDX_W-1:0]          r_index;
  logic [7:0]                  r_timer;
  logic                        r_done;
  logic                        r_busy;
  logic                        r_serviced;
  logic [c_ID_W-1:0]           r_id;
  logic [15:0]                 r_count;
  logic [PRIO_W-1:0]           w_field;
  logic                        w_start;
  logic                        w_take;
  logic                        w_idx_last;
  logic                        w_idx_inc;
  logic                        w_cfg_fin;

  assign w_field    = r_table[r_index*PRIO_W +: PRIO_W];
  assign w_idx_last = (r_index == c_IDX_W'(NUM_INTR - 1));
  // a pending interrupt in READY wins over a new programming request
  assign w_start    = cfg_start_i &&
                      ((r_state == IDLE) || ((r_state == READY) && !intr_valid_i));
  assign w_take     = (r_state == READY) && intr_valid_i;

  intr_host_bus_seq #(
    .PRIO_W (PRIO_W)
  ) u_bus_seq (
    .pclk_i     (pclk_i),
    .prst_i     (prst_i),
    .state_i    (r_state),
    .addr_i     (8'(r_index)),
    .field_i    (w_field),
    .idx_last_i (w_idx_last),
    .cfg_clr_i  (w_start),
    .prdata_i   (prdata_i),
    .pready_i   (pready_i),
    .paddr_o    (paddr_o),
    .pwdata_o   (pwdata_o),
    .pwrite_o   (pwrite_o),
    .penable_o  (penable_o),
    .next_o     (w_cfg_next),
    .idx_inc_o  (w_idx_inc),
    .cfg_fin_o  (w_cfg_fin),
    .cfg_err_o  (cfg_err_o)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_start) w_next = CFG_WR;
      READY: begin
        if (w_take)       w_next = SVC;
        else if (w_start) w_next = CFG_WR;
      end
      SVC:     if (r_timer <= 8'd1) w_next = ACK;
      ACK:     w_next = DROP;
      DROP:    if (!intr_valid_i) w_next = READY;
      default: w_next = w_cfg_next;
    endcase
  end

  always_ff @(posedge pclk_i) begin
    if (!prst_i) begin
      r_state    <= IDLE;
      r_table    <= '0;
      r_index    <= '0;
      r_timer    <= '0;
      r_done     <= 1'b0;
      r_busy     <= 1'b0;
      r_serviced <= 1'b0;
      r_id       <= '0;
      r_count    <= '0;
    end else begin
      r_state    <= w_next;
      // registered pulse gives the N+2 service latency
      r_serviced <= (r_state == ACK);
      if (w_start) begin
        r_table <= cfg_prio_i;
        r_index <= '0;
        r_done  <= 1'b0;
      end else if (w_idx_inc) begin
        r_index <= r_index + c_IDX_W'(1);
      end
      if (w_cfg_fin) r_done <= 1'b1;
      if (w_take) begin
        r_id    <= intr_to_service_i;
        r_busy  <= 1'b1;
        r_timer <= (svc_cycles_i == 8'd0) ? 8'd1 : svc_cycles_i;
      end else if (r_state == SVC) begin
        r_timer <= r_timer - 8'd1;
      end
      if (r_state == ACK) begin
        r_busy  <= 1'b0;
        r_count <= r_count + 16'd1;
      end
    end
  end

  assign cfg_done_o      = r_done;
  assign svc_busy_o      = r_busy;
  assign intr_serviced_o = r_serviced;
  assign svc_id_o        = r_id;
  assign svc_count_o     = r_count;

endmodule
`default_nettype wire

// File: tb/tb_intr_host_agent.sv
`default_nettype none
// ============================================================================
// tb_intr_host_agent : directed self-checking bench for intr_host_agent
// Optional feature macro: INTR_HOST_READBACK_EN (enables readback expectations)
// Revision : 1.0  initial release
// ============================================================================
module tb_intr_host_agent;

  localparam int NI = 16;
  localparam int PW = 4;

  logic           pclk_i = 1'b0;
  logic           prst_i = 1'b0;
  logic           cfg_start_i = 1'b0;
  logic [NI*PW-1:0] cfg_prio_i = '0;
  logic           cfg_done_o, cfg_err_o;
  logic [7:0]     paddr_o, pwdata_o;
  logic           pwrite_o, penable_o;
  logic [7:0]     prdata_i = 8'h00;
  logic           pready_i = 1'b0;
  logic [3:0]     intr_to_service_i = 4'h0;
  logic           intr_valid_i = 1'b0;
  logic           intr_serviced_o;
  logic [7:0]     svc_cycles_i = 8'h00;
  logic           svc_busy_o;
  logic [3:0]     svc_id_o;
  logic [15:0]    svc_count_o;

  int n_chk = 0;
  int n_pass = 0;
  int wr_n = 0;
  int rd_n = 0;
  int gap_viol = 0;
  int pulse_n = 0;
  int wait_cnt = 0;
  bit gap_pend = 1'b0;
  logic [7:0] wr_addr [64];
  logic [7:0] wr_data [64];

  intr_host_agent dut (
    .pclk_i            (pclk_i),
    .prst_i            (prst_i),
    .cfg_start_i       (cfg_start_i),
    .cfg_prio_i        (cfg_prio_i),
    .cfg_done_o        (cfg_done_o),
    .cfg_err_o         (cfg_err_o),
    .paddr_o           (paddr_o),
    .pwdata_o          (pwdata_o),
    .pwrite_o          (pwrite_o),
    .penable_o         (penable_o),
    .prdata_i          (prdata_i),
    .pready_i          (pready_i),
    .intr_to_service_i (intr_to_service_i),
    .intr_valid_i      (intr_valid_i),
    .intr_serviced_o   (intr_serviced_o),
    .svc_cycles_i      (svc_cycles_i),
    .svc_busy_o        (svc_busy_o),
    .svc_id_o          (svc_id_o),
    .svc_count_o       (svc_count_o)
  );

  always #5 pclk_i = ~pclk_i;

  // bus responder: pready one cycle after penable rises; logs each access
  always @(negedge pclk_i) begin
    if (intr_serviced_o) pulse_n++;
    if (gap_pend && penable_o) gap_viol++;
    gap_pend = 1'b0;
    prdata_i = (paddr_o == 8'd3) ? 8'h07 : paddr_o;
    if (penable_o && !pready_i) begin
      if (wait_cnt == 1) begin
        pready_i = 1'b1;
        gap_pend = 1'b1;
        wait_cnt = 0;
        if (pwrite_o) begin
          if (wr_n < 64) begin
            wr_addr[wr_n] = paddr_o;
            wr_data[wr_n] = pwdata_o;
          end
          wr_n++;
        end else begin
          rd_n++;
        end
      end else begin
        wait_cnt++;
      end
    end else begin
      pready_i = 1'b0;
      wait_cnt = 0;
    end
  end

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic wait_cfg_done(input string tag);
    int cyc;
    cyc = 0;
    while (!cfg_done_o && cyc < 300) begin
      @(negedge pclk_i);
      cyc++;
    end
    chk_eq(tag, 32'(cfg_done_o), 32'd1);
  endtask

  task automatic pulse_start();
    @(negedge pclk_i);
    cfg_start_i = 1'b1;
    @(negedge pclk_i);
    cfg_start_i = 1'b0;
  endtask

  initial begin
    int lat;
    int early_busy;
    for (int i = 0; i < NI; i++) cfg_prio_i[i*PW +: PW] = PW'(i);

    // reset state
    repeat (3) @(negedge pclk_i);
    chk_eq("rst_done",    32'(cfg_done_o),      32'd0);
    chk_eq("rst_penable", 32'(penable_o),       32'd0);
    chk_eq("rst_count",   32'(svc_count_o),     32'd0);
    chk_eq("rst_busy",    32'(svc_busy_o),      32'd0);
    chk_eq("rst_pulse",   32'(intr_serviced_o), 32'd0);
    chk_eq("rst_err",     32'(cfg_err_o),       32'd0);
    prst_i = 1'b1;

    // valid raised before configuration: must be held off until READY
    intr_to_service_i = 4'd5;
    svc_cycles_i      = 8'd3;
    intr_valid_i      = 1'b1;
    pulse_start();
    early_busy = 0;
    lat = 0;
    while (!cfg_done_o && lat < 300) begin
      if (svc_busy_o) early_busy++;
      @(negedge pclk_i);
      lat++;
    end
    chk_eq("cfg_done", 32'(cfg_done_o), 32'd1);
    chk_eq("held_off_busy", 32'(early_busy), 32'd0);
    chk_eq("wr_count", 32'(wr_n), 32'd16);
    for (int i = 0; i < NI; i++) begin
      chk_eq($sformatf("wr_addr_%0d", i), 32'(wr_addr[i]), 32'(i));
      chk_eq($sformatf("wr_data_%0d", i), 32'(wr_data[i]), 32'(i));
    end
    chk_eq("gap_viol", 32'(gap_viol), 32'd0);
`ifdef INTR_HOST_READBACK_EN
    chk_eq("rd_count", 32'(rd_n), 32'd16);
    chk_eq("cfg_err_set", 32'(cfg_err_o), 32'd1);
`else
    chk_eq("rd_count", 32'(rd_n), 32'd0);
    chk_eq("cfg_err_tied", 32'(cfg_err_o), 32'd0);
`endif

    // service N=3 -> pulse 5 cycles after the READY sampling cycle
    @(negedge pclk_i);
    chk_eq("busy_in_svc", 32'(svc_busy_o), 32'd1);
    chk_eq("svc_id_5",    32'(svc_id_o),   32'd5);
    cfg_start_i = 1'b1;
    @(negedge pclk_i);
    cfg_start_i = 1'b0;
    lat = 2;
    while (!intr_serviced_o && lat < 100) begin
      @(negedge pclk_i);
      lat++;
    end
    chk_eq("lat_n3",        32'(lat),         32'd5);
    chk_eq("busy_at_ack",   32'(svc_busy_o),  32'd0);
    chk_eq("count_1",       32'(svc_count_o), 32'd1);
    @(negedge pclk_i);
    chk_eq("pulse_one_cyc", 32'(intr_serviced_o), 32'd0);

    // valid held high: no second service
    repeat (8) @(negedge pclk_i);
    chk_eq("held_valid_count",  32'(svc_count_o), 32'd1);
    chk_eq("held_valid_pulses", 32'(pulse_n),     32'd1);
    chk_eq("start_ignored_done", 32'(cfg_done_o), 32'd1);
    chk_eq("start_ignored_wr",  32'(wr_n),        32'd16);
    intr_valid_i = 1'b0;
    repeat (2) @(negedge pclk_i);

    // zero duration -> latency 3
    intr_to_service_i = 4'd9;
    svc_cycles_i      = 8'd0;
    intr_valid_i      = 1'b1;
    lat = 0;
    do begin
      @(negedge pclk_i);
      lat++;
    end while (!intr_serviced_o && lat < 100);
    chk_eq("lat_n0",   32'(lat),         32'd3);
    chk_eq("svc_id_9", 32'(svc_id_o),    32'd9);
    chk_eq("count_2",  32'(svc_count_o), 32'd2);
    intr_valid_i = 1'b0;
    @(negedge pclk_i);

    // counter wrap after 65535 services
    dut.r_count = 16'hFFFF;
    intr_to_service_i = 4'd3;
    svc_cycles_i      = 8'd2;
    intr_valid_i      = 1'b1;
    lat = 0;
    do begin
      @(negedge pclk_i);
      lat++;
    end while (!intr_serviced_o && lat < 100);
    chk_eq("lat_n2",     32'(lat),         32'd4);
    chk_eq("count_wrap", 32'(svc_count_o), 32'd0);
    intr_valid_i = 1'b0;
    @(negedge pclk_i);

    // reset during the write of index 8
    pulse_start();
    lat = 0;
    while (!(penable_o && pwrite_o && paddr_o == 8'd8) && lat < 300) begin
      @(negedge pclk_i);
      lat++;
    end
    chk_eq("reach_idx8", 32'(paddr_o), 32'd8);
    prst_i = 1'b0;
    @(negedge pclk_i);
    chk_eq("mid_rst_penable", 32'(penable_o),   32'd0);
    chk_eq("mid_rst_done",    32'(cfg_done_o),  32'd0);
    chk_eq("mid_rst_count",   32'(svc_count_o), 32'd0);
    chk_eq("mid_rst_id",      32'(svc_id_o),    32'd0);
    chk_eq("mid_rst_paddr",   32'(paddr_o),     32'd0);
    chk_eq("mid_rst_err",     32'(cfg_err_o),   32'd0);
    wr_n = 0;
    rd_n = 0;
    @(negedge pclk_i);
    prst_i = 1'b1;
    pulse_start();
    chk_eq("restart_err_clr", 32'(cfg_err_o), 32'd0);
    wait_cfg_done("restart_done");
    chk_eq("restart_wr_count", 32'(wr_n),        32'd16);
    chk_eq("restart_addr0",    32'(wr_addr[0]),  32'd0);
    chk_eq("restart_data15",   32'(wr_data[15]), 32'd15);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
